// File: rtl/write_resp_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : write_resp_rr_scheduler
// Brief    : Round-robin B-channel scheduler: grants one of two downstream
//            responses, holds it, and routes it by BID to S00 or S01.
// Revision : 1.0 - initial release
// ============================================================================
module write_resp_rr_scheduler #(
    parameter int Num_Of_Masters  = 2,
    parameter int Master_ID_Width = $clog2(Num_Of_Masters),
    parameter int M1_ID           = 0,
    parameter int M2_ID           = 1
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [Master_ID_Width-1:0] M00_AXI_BID,
    input  logic [1:0]                 M00_AXI_bresp,
    input  logic                       M00_AXI_bvalid,
    output logic                       M00_AXI_bready,
    input  logic [Master_ID_Width-1:0] M01_AXI_BID,
    input  logic [1:0]                 M01_AXI_bresp,
    input  logic                       M01_AXI_bvalid,
    output logic                       M01_AXI_bready,
    output logic [1:0]                 S00_AXI_bresp,
    output logic                       S00_AXI_bvalid,
    input  logic                       S00_AXI_bready,
    output logic [1:0]                 S01_AXI_bresp,
    output logic                       S01_AXI_bvalid,
    input  logic                       S01_AXI_bready,
    output logic                       Granted_Source,
    output logic                       Route_Err
);

    localparam logic [Master_ID_Width-1:0] c_m1_id = Master_ID_Width'(M1_ID);
    localparam logic [Master_ID_Width-1:0] c_m2_id = Master_ID_Width'(M2_ID);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                     r_state;
    logic                       r_ptr;
    logic                       r_granted;
    logic                       r_route_err;
    logic                       r_s00_bvalid;
    logic                       r_s01_bvalid;
    logic [1:0]                 r_s00_bresp;
    logic [1:0]                 r_s01_bresp;

    logic                       w_grant;
    logic                       w_pick_m01;
    logic                       w_accept;
    logic [Master_ID_Width-1:0] w_bid;
    logic [1:0]                 w_bresp;
    logic                       w_hit0;
    logic                       w_hit1;
    logic                       w_done;

    // The pointer source has priority; the other source wins only if the pointer source is idle.
    always_comb begin
        w_grant    = 1'b0;
        w_pick_m01 = 1'b0;
        if (r_ptr == 1'b0) begin
            if (M00_AXI_bvalid) begin
                w_grant    = 1'b1;
                w_pick_m01 = 1'b0;
            end else if (M01_AXI_bvalid) begin
                w_grant    = 1'b1;
                w_pick_m01 = 1'b1;
            end
        end else begin
            if (M01_AXI_bvalid) begin
                w_grant    = 1'b1;
                w_pick_m01 = 1'b1;
            end else if (M00_AXI_bvalid) begin
                w_grant    = 1'b1;
                w_pick_m01 = 1'b0;
            end
        end
    end

    assign w_accept       = !ARESETN && (r_state == ST_IDLE) && w_grant;
    assign M00_AXI_bready = w_accept && !w_pick_m01;
    assign M01_AXI_bready = w_accept && w_pick_m01;

    assign w_bid   = w_pick_m01 ? M01_AXI_BID   : M00_AXI_BID;
    assign w_bresp = w_pick_m01 ? M01_AXI_bresp : M00_AXI_bresp;
    assign w_hit0  = (w_bid == c_m1_id);
    assign w_hit1  = (w_bid == c_m2_id);
    assign w_done  = (r_s00_bvalid && S00_AXI_bready) || (r_s01_bvalid && S01_AXI_bready);

    always_ff @(posedge ACLK) begin
        if (ARESETN) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_granted    <= 1'b0;
            r_route_err  <= 1'b0;
            r_s00_bvalid <= 1'b0;
            r_s01_bvalid <= 1'b0;
            r_s00_bresp  <= 2'b00;
            r_s01_bresp  <= 2'b00;
        end else begin
            r_route_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_granted <= w_pick_m01;
                        r_ptr     <= ~w_pick_m01;
                        // S00 takes precedence when both route IDs coincide.
                        if (w_hit0) begin
                            r_s00_bvalid <= 1'b1;
                            r_s00_bresp  <= w_bresp;
                            r_state      <= ST_HOLD;
                        end else if (w_hit1) begin
                            r_s01_bvalid <= 1'b1;
                            r_s01_bresp  <= w_bresp;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_route_err <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_done) begin
                        r_s00_bvalid <= 1'b0;
                        r_s01_bvalid <= 1'b0;
                        r_s00_bresp  <= 2'b00;
                        r_s01_bresp  <= 2'b00;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign S00_AXI_bvalid = r_s00_bvalid;
    assign S00_AXI_bresp  = r_s00_bresp;
    assign S01_AXI_bvalid = r_s01_bvalid;
    assign S01_AXI_bresp  = r_s01_bresp;
    assign Granted_Source = r_granted;
    assign Route_Err      = r_route_err;

endmodule
`default_nettype wire
